// File: rtl/router_pkg.sv
// Shared definitions for the router ingress path: parity modes, header layout
// and the accumulator operator.
package router_pkg;

  localparam int unsigned PARITY_XOR = 0;
  localparam int unsigned PARITY_SUM = 1;

  // Header length field occupies header[DW-1:LEN_LSB]
  localparam int unsigned LEN_LSB = 2;

  // Operand width of parity_op; callers zero-extend in and truncate out
  localparam int unsigned OP_W = 64;

  function automatic logic [OP_W-1:0] parity_op(input logic            mode,
                                                input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
    return mode ? (a + b) : (a ^ b);
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Circular hold buffer used while the destination FIFO is full.
// Pushes to a full buffer are ignored; clr empties it in one cycle.
module router_hold_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok_c, pop_ok_c;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_ok_c  = push & ~full_q;
  assign pop_ok_c   = pop & ~empty_q;
  assign pop_data_c = mem_q[rd_ptr_q];
  assign full       = full_q;
  assign empty      = empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_c) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop_ok_c) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      cnt_d = cnt_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end
    // Flags are registered from the next occupancy so they are glitch-free
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/router_pkt_reg_p.sv
// Router ingress packet register: forwards header/payload/parity to the output
// FIFO, holds bytes while it is full, and checks parity and payload length.
module router_pkt_reg_p
  import router_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned HOLD_DEPTH  = 2,
  parameter int unsigned PARITY_MODE = PARITY_XOR
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] data_out,
  output logic          dout_valid,
  output logic          hold_empty,
  output logic          hold_ovf,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err,
  output logic          len_err
);

  localparam int unsigned CNT_W    = DW - LEN_LSB;
  localparam int unsigned HW       = DW + 1;
  localparam logic        SUM_MODE = (PARITY_MODE == PARITY_SUM);

  logic [DW-1:0]    header_q, header_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    par_q, par_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pdone_q, pdone_d;
  logic             pdone_prev_q, pdone_prev_d;
  logic             dvalid_q, dvalid_d;
  logic             ovf_q, ovf_d;
  logic             lpv_q, lpv_d;
  logic             err_q, err_d;
  logic             len_err_q, len_err_d;

  logic             hold_clr_c, hold_push_c, hold_pop_c;
  logic             hold_full;
  logic [HW-1:0]    hold_rd_c;
  logic [CNT_W-1:0] len_exp_c;
  logic             cmp_c;
  logic             unused_c;

  function automatic logic [DW-1:0] acc_op(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    return DW'(parity_op(SUM_MODE, OP_W'(a), OP_W'(b)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Hold entries are tagged with bit DW set when they carry the parity byte
  router_hold_fifo #(
    .W     (HW),
    .DEPTH (HOLD_DEPTH)
  ) u_hold (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (hold_clr_c),
    .push       (hold_push_c),
    .pop        (hold_pop_c),
    .push_data  ({~pkt_valid, data_in}),
    .pop_data_c (hold_rd_c),
    .full       (hold_full),
    .empty      (hold_empty)
  );

  assign len_exp_c = header_q[DW-1:LEN_LSB];
  assign cmp_c     = pdone_q & ~pdone_prev_q;
  assign unused_c  = ^{full_state, header_q[LEN_LSB-1:0]};

  always_comb begin
    header_d     = header_q;
    acc_d        = acc_q;
    par_d        = par_q;
    dout_d       = dout_q;
    cnt_d        = cnt_q;
    pdone_d      = pdone_q;
    pdone_prev_d = pdone_q;
    dvalid_d     = 1'b0;
    ovf_d        = ovf_q;
    lpv_d        = lpv_q;
    err_d        = err_q;
    len_err_d    = len_err_q;
    hold_clr_c   = 1'b0;
    hold_push_c  = 1'b0;
    hold_pop_c   = 1'b0;

    // Verdict is taken once, the cycle after the parity byte lands
    if (cmp_c) begin
      err_d     = (acc_q != par_q);
      len_err_d = (cnt_q != len_exp_c) | ovf_q;
    end

    if (rst_int_reg) begin
      lpv_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      lpv_d = 1'b1;
    end

    if (detect_add) begin
      acc_d      = '0;
      cnt_d      = '0;
      pdone_d    = 1'b0;
      ovf_d      = 1'b0;
      hold_clr_c = 1'b1;
      if (pkt_valid) begin
        header_d = data_in;
      end
    end else if (lfd_state) begin
      dout_d   = header_q;
      dvalid_d = 1'b1;
      acc_d    = acc_op(acc_q, header_q);
    end else if (ld_state) begin
      if (!fifo_full) begin
        dout_d   = data_in;
        dvalid_d = 1'b1;
        if (pkt_valid) begin
          acc_d = acc_op(acc_q, data_in);
          cnt_d = sat_inc(cnt_q);
        end else begin
          par_d   = data_in;
          pdone_d = 1'b1;
        end
      end else begin
        hold_push_c = 1'b1;
        if (hold_full) begin
          ovf_d = 1'b1;
        end
      end
    end else if (laf_state && !fifo_full && !hold_empty) begin
      hold_pop_c = 1'b1;
      dout_d     = hold_rd_c[DW-1:0];
      dvalid_d   = 1'b1;
      if (hold_rd_c[DW]) begin
        par_d   = hold_rd_c[DW-1:0];
        pdone_d = 1'b1;
      end else begin
        acc_d = acc_op(acc_q, hold_rd_c[DW-1:0]);
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      header_q     <= '0;
      acc_q        <= '0;
      par_q        <= '0;
      dout_q       <= '0;
      cnt_q        <= '0;
      pdone_q      <= 1'b0;
      pdone_prev_q <= 1'b0;
      dvalid_q     <= 1'b0;
      ovf_q        <= 1'b0;
      lpv_q        <= 1'b0;
      err_q        <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      header_q     <= header_d;
      acc_q        <= acc_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      cnt_q        <= cnt_d;
      pdone_q      <= pdone_d;
      pdone_prev_q <= pdone_prev_d;
      dvalid_q     <= dvalid_d;
      ovf_q        <= ovf_d;
      lpv_q        <= lpv_d;
      err_q        <= err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign data_out      = dout_q;
  assign dout_valid    = dvalid_q;
  assign hold_ovf      = ovf_q;
  assign parity_done   = pdone_q;
  assign low_pkt_valid = lpv_q;
  assign err           = err_q;
  assign len_err       = len_err_q;

endmodule

// File: doc/router_pkt_reg_p.md
# router_pkt_reg_p

Parametrised packet data register and integrity checker for the router ingress path. It sits between the router FSM and the per-port output FIFOs. It captures the header, forwards payload and parity bytes, and buffers up to HOLD_DEPTH bytes while the destination FIFO is full. It checks both parity (XOR or additive checksum) and payload length against the header length field.

## Interface
- DW, 8: data width in bits, ≥4.
- HOLD_DEPTH, 2: hold-buffer entries used while the FIFO is full, ≥1.
- PARITY_MODE, 0: 0 = bytewise XOR; 1 = two's-complement sum mod 2^DW.

Ports (reset resetn, synchronous, active-low; clock clk):
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  high on header/payload bytes, low on the parity byte.
- data_in  in  DW  byte from the source.
- fifo_full  in  1  selected output FIFO is full.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  one-hot FSM state strobes.
- rst_int_reg  in  1  clears low_pkt_valid.
- data_out  out  DW  byte to the FIFO.
- dout_valid  out  1  data_out carries a new byte this cycle (FIFO write enable).
- hold_empty  out  1  hold buffer empty.
- hold_ovf  out  1  sticky: a byte was dropped on a push to a full hold buffer.
- parity_done  out  1  parity byte accepted.
- low_pkt_valid  out  1  pkt_valid fell while in ld_state.
- err  out  1  parity mismatch.
- len_err  out  1  payload count ≠ header length, or overflow occurred.

## Operation
- Priority, highest first:
  - reset;
  - detect_add, which clears parity_done, accumulators, the payload counter, hold pointers and hold_ovf;
  - ld_state;
  - laf_state.
- ld_state and laf_state both high: ld_state wins.
- Header capture:
  - detect_add && pkt_valid: header_reg <= data_in.
  - len_exp = header[DW-1:2].
- lfd_state:
  - data_out <= header_reg, dout_valid = 1.
  - acc <= acc ⊕ header_reg, where ⊕ is XOR (PARITY_MODE 0) or add mod 2^DW (PARITY_MODE 1).
- ld_state && !fifo_full:
  - data_out <= data_in, dout_valid = 1.
  - If pkt_valid: acc ⊕= data_in, count++ (count saturates at all-ones, DW-2 bits).
  - If !pkt_valid: packet_parity <= data_in, parity_done <= 1.
- ld_state && fifo_full:
  - Push {!pkt_valid, data_in} into the hold buffer; no dout_valid.
  - Buffer full: byte dropped, hold_ovf <= 1.
- laf_state && !fifo_full && !hold_empty:
  - Pop one entry per cycle to data_out, dout_valid = 1.
  - Payload entries update acc and count.
  - Parity-tagged entries load packet_parity and set parity_done.
- Any other condition: data_out holds, dout_valid = 0.
- low_pkt_valid: set on ld_state && !pkt_valid; cleared by rst_int_reg or reset.
- Compare, in the cycle after parity_done rises:
  - err <= (acc ≠ packet_parity);
  - len_err <= (count ≠ len_exp) | hold_ovf.
  - Both hold until the next compare or reset; detect_add does not clear them.
- full_state does not affect data; it is included for FSM completeness.

## Timing
- All outputs are registered.
- Reset values: data_out = 0, dout_valid = 0, hold_empty = 1, every other output 0.
- data_out / dout_valid appear one cycle after the qualifying strobe edge.
- err / len_err appear two cycles after the parity byte is accepted, whether directly or by pop.
- Hold buffer is a circular FIFO of HOLD_DEPTH entries with wrap-around pointers. FIFO order is preserved across fifo_full toggling within laf_state.
- Reset mid-packet: everything returns to reset values on the next edge and the partial packet is discarded.

## Structure
- Shared package router_pkg holds:
  - PARITY_XOR = 0 and PARITY_SUM = 1 localparams;
  - header length-field LSB position (2);
  - a function parity_op(mode, a, b).
- One sub-module: router_hold_fifo, a synchronous FIFO of HOLD_DEPTH × (DW+1) bits with push, pop, full, empty.
- Accumulator, counter and compare logic stay in the top level.

## Test plan
- XOR, DW=8, with stimulus:
  - header 8'h0C, so len 3;
  - payload 11, 22, 33;
  - parity 0C.
  - Expected: dout_valid pulses carrying 0C, 11, 22, 33, 0C; parity_done = 1; two cycles later err = 0, len_err = 0.
- Same packet with parity 0D: err = 1, len_err = 0; err holds through the next detect_add.
- HOLD_DEPTH=2: fifo_full high during bytes 22 and 33.
  - hold_empty goes to 0 and nothing is written.
  - laf_state with fifo_full low pops 22 then 33 on consecutive cycles.
  - hold_empty returns to 1 and err = 0.
- Overflow: fifo_full held across 3 ld_state payload bytes with HOLD_DEPTH=2. Expected: third byte dropped, hold_ovf = 1, len_err = 1.
- PARITY_MODE=1: header 08, payload 80, 90, parity 18 (0x118 mod 256). Expected: err = 0, len_err = 0; parity 19 gives err = 1.
- resetn low for one cycle mid-payload: all outputs return to reset values. The next clean packet then passes with err = 0.
